arb_mux_n: RTL and testbench

Parametrised N-channel buffered arbiter. Each input channel writes into its own synchronous FIFO; a round-robin arbiter with configurable burst hold pops one word per cycle from the non-empty FIFOs into a registered output stage that honours downstream back-pressure. It replaces the fixed three-channel arbiter top and adds a real ready/valid output handshake, channel tagging and multi-beat hold.

---
 rtl/arb_pkg.sv | 17 +
 rtl/arb_mux_n_chan_fifo.sv | 56 +++++
 rtl/arb_mux_n.sv | 110 +++++++++++
 tb/tb_arb_mux_n.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared helpers for the N-channel buffered arbiter: width derivations used by
// the top and the per-channel FIFOs.
package arb_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Channel-index width; a single bit is kept even for degenerate counts.
    function automatic int chanWidth(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_n_chan_fifo.sv
// Per-channel synchronous FIFO with registered occupancy count and a
// combinational head word; full FIFOs refuse pushes, empty ones ignore pops.
module chan_fifo
    import arb_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             full;
    logic             doPush;
    logic             doPop;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign head   = mem[rdPtr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstN && doPush) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel buffered arbiter: per-channel FIFOs drained one word per cycle by a
// round-robin arbiter with burst hold into a ready/valid output register.
module arb_mux_n
    import arb_pkg::*;
#(
    parameter int N        = 3,
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 8,
    parameter int HOLD_MAX = 1,
    localparam int CH_W    = chanWidth(N)
) (
    input  logic               CLK,
    input  logic               SynReset_N,
    input  logic [N-1:0]       i_DataValid,
    input  logic [N*WIDTH-1:0] i_DataIn,
    output logic [N-1:0]       o_DataGrant,
    input  logic               i_DataGrant_D,
    output logic               o_DataValid_D,
    output logic [WIDTH-1:0]   o_DataOut_D,
    output logic [CH_W-1:0]    o_DataChan_D
);

    localparam int RUN_W = clog2(HOLD_MAX + 1);
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(HOLD_MAX);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N - 1);

    // Run length saturates so a lone busy channel cannot wrap back under the hold limit.
    function automatic logic [RUN_W-1:0] satInc(input logic [RUN_W-1:0] v);
        return (v == RUN_MAX) ? v : v + 1'b1;
    endfunction

    logic [WIDTH-1:0] heads  [N];
    logic [CNT_W-1:0] counts [N];
    logic [N-1:0]     empties;
    logic [N-1:0]     popVec;

    logic [CH_W-1:0]  cur;
    logic [RUN_W-1:0] run;
    logic [CH_W-1:0]  sel;
    logic             pop;

    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic [CH_W-1:0]  chan_p1;

    for (genvar k = 0; k < N; k++) begin : gFifo
        chan_fifo #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH)
        ) uFifo (
            .clk   (CLK),
            .rstN  (SynReset_N),
            .push  (i_DataValid[k]),
            .pop   (popVec[k]),
            .wrData(i_DataIn[k*WIDTH +: WIDTH]),
            .head  (heads[k]),
            .count (counts[k]),
            .empty (empties[k])
        );
        assign o_DataGrant[k] = (counts[k] != CNT_W'(DEPTH));
    end

    // Stay on cur while under the hold limit, else scan cur+1.. with cur last.
    always_comb begin
        logic            found;
        logic [CH_W-1:0] idx;
        sel   = cur;
        found = !empties[cur] && (run < RUN_MAX);
        idx   = cur;
        for (int k = 1; k <= N; k++) begin
            idx = CH_W'((int'(cur) + k) % N);
            if (!found && !empties[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign pop    = (|(~empties)) && (!vld_p1 || i_DataGrant_D);
    assign popVec = pop ? (N'(1) << sel) : '0;

    // Stage p1: output register, advanced only when empty or accepted downstream.
    always_ff @(posedge CLK) begin
        if (!SynReset_N) begin
            cur     <= LAST_CH;
            run     <= RUN_MAX;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            chan_p1 <= '0;
        end else if (pop) begin
            if (sel == cur) begin
                run <= satInc(run);
            end else begin
                cur <= sel;
                run <= RUN_W'(1);
            end
            vld_p1  <= 1'b1;
            data_p1 <= heads[sel];
            chan_p1 <= sel;
        end else if (i_DataGrant_D) begin
            vld_p1 <= 1'b0;
        end
    end

    assign o_DataValid_D = vld_p1;
    assign o_DataOut_D   = data_p1;
    assign o_DataChan_D  = chan_p1;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed bench for arb_mux_n: one instance with pure round-robin, one with a
// burst hold of 3, both fed the same stimulus.
module tb_arb_mux_n;

    logic         clk = 1'b0;
    logic         rstN;
    logic [2:0]   dataValid;
    logic [191:0] dataIn;
    logic         ready;
    logic [2:0]   grant, grant3;
    logic         vld, vld3;
    logic [63:0]  dOut, dOut3;
    logic [1:0]   chan, chan3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arb_mux_n #(.N(3), .WIDTH(64), .DEPTH(8), .HOLD_MAX(1)) dut (
        .CLK          (clk),
        .SynReset_N   (rstN),
        .i_DataValid  (dataValid),
        .i_DataIn     (dataIn),
        .o_DataGrant  (grant),
        .i_DataGrant_D(ready),
        .o_DataValid_D(vld),
        .o_DataOut_D  (dOut),
        .o_DataChan_D (chan)
    );

    arb_mux_n #(.N(3), .WIDTH(64), .DEPTH(8), .HOLD_MAX(3)) dut3 (
        .CLK          (clk),
        .SynReset_N   (rstN),
        .i_DataValid  (dataValid),
        .i_DataIn     (dataIn),
        .o_DataGrant  (grant3),
        .i_DataGrant_D(ready),
        .o_DataValid_D(vld3),
        .o_DataOut_D  (dOut3),
        .o_DataChan_D (chan3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstN      = 1'b0;
        dataValid = 3'b000;
        dataIn    = '0;
        ready     = 1'b1;
        step();
        step();
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        total++; if (vld !== 1'b0)     begin bad++; $display("FAIL reset_vld got=%b want=0", vld); end
        total++; if (dOut !== 64'h0)   begin bad++; $display("FAIL reset_data got=%h want=0", dOut); end
        total++; if (chan !== 2'd0)    begin bad++; $display("FAIL reset_chan got=%0d want=0", chan); end
        total++; if (grant !== 3'b111) begin bad++; $display("FAIL reset_grant got=%b want=111", grant); end
        total++; if (vld3 !== 1'b0)    begin bad++; $display("FAIL reset_vld3 got=%b want=0", vld3); end
        step();
        total++; if (grant !== 3'b111) begin bad++; $display("FAIL idle_grant got=%b want=111", grant); end
    endtask

    task automatic test_first_word();
        doReset();
        dataValid = 3'b001;
        dataIn[63:0] = 64'hA0;
        step();
        dataValid = 3'b000;
        total++; if (vld !== 1'b0) begin bad++; $display("FAIL first_early got=%b want=0", vld); end
        step();
        total++; if (vld !== 1'b1)   begin bad++; $display("FAIL first_vld got=%b want=1", vld); end
        total++; if (dOut !== 64'hA0) begin bad++; $display("FAIL first_data got=%h want=a0", dOut); end
        total++; if (chan !== 2'd0)   begin bad++; $display("FAIL first_chan got=%0d want=0", chan); end
        step();
        total++; if (vld !== 1'b0) begin bad++; $display("FAIL first_drop got=%b want=0", vld); end
    endtask

    task automatic test_round_robin();
        int hc[12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2};
        int hi[12] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3};
        doReset();
        for (int c = 0; c < 14; c++) begin
            dataValid = (c < 4) ? 3'b111 : 3'b000;
            for (int k = 0; k < 3; k++) dataIn[k*64 +: 64] = 64'(k * 16 + c);
            step();
            if (c >= 1 && c <= 12) begin
                total++; if (vld !== 1'b1) begin bad++; $display("FAIL rr_vld c=%0d got=%b want=1", c, vld); end
                total++; if (chan !== 2'((c - 1) % 3)) begin bad++; $display("FAIL rr_chan c=%0d got=%0d want=%0d", c, chan, (c - 1) % 3); end
                total++; if (dOut !== 64'(((c - 1) % 3) * 16 + (c - 1) / 3)) begin bad++; $display("FAIL rr_data c=%0d got=%h want=%h", c, dOut, ((c - 1) % 3) * 16 + (c - 1) / 3); end
                total++; if (vld3 !== 1'b1) begin bad++; $display("FAIL hold_vld c=%0d got=%b want=1", c, vld3); end
                total++; if (chan3 !== 2'(hc[c-1])) begin bad++; $display("FAIL hold_chan c=%0d got=%0d want=%0d", c, chan3, hc[c-1]); end
                total++; if (dOut3 !== 64'(hc[c-1] * 16 + hi[c-1])) begin bad++; $display("FAIL hold_data c=%0d got=%h want=%h", c, dOut3, hc[c-1] * 16 + hi[c-1]); end
            end
        end
        total++; if (vld !== 1'b0)  begin bad++; $display("FAIL rr_end got=%b want=0", vld); end
        total++; if (vld3 !== 1'b0) begin bad++; $display("FAIL hold_end got=%b want=0", vld3); end
    endtask

    task automatic test_full();
        doReset();
        ready = 1'b0;
        dataValid = 3'b001;
        dataIn[63:0] = 64'hC0;
        step();
        dataValid = 3'b000;
        step();
        total++; if (dOut !== 64'hC0) begin bad++; $display("FAIL full_park got=%h want=c0", dOut); end
        for (int i = 0; i < 8; i++) begin
            dataValid = 3'b010;
            dataIn[127:64] = 64'(8'hB0 + i);
            step();
            total++; if (grant[1] !== (i == 7 ? 1'b0 : 1'b1)) begin bad++; $display("FAIL full_grant i=%0d got=%b want=%b", i, grant[1], (i != 7)); end
        end
        dataIn[127:64] = 64'hBF;
        step();
        total++; if (grant[1] !== 1'b0) begin bad++; $display("FAIL full_drop_grant got=%b want=0", grant[1]); end
        total++; if (vld !== 1'b1 || chan !== 2'd0 || dOut !== 64'hC0) begin bad++; $display("FAIL full_frozen got=%b/%0d/%h want=1/0/c0", vld, chan, dOut); end
        ready = 1'b1;
        dataIn[127:64] = 64'hBE;
        step();
        dataValid = 3'b000;
        total++; if (grant[1] !== 1'b1) begin bad++; $display("FAIL full_refill got=%b want=1", grant[1]); end
        for (int i = 0; i < 8; i++) begin
            total++; if (vld !== 1'b1 || chan !== 2'd1 || dOut !== 64'(8'hB0 + i)) begin bad++; $display("FAIL full_drain i=%0d got=%b/%0d/%h want=1/1/%h", i, vld, chan, dOut, 8'hB0 + i); end
            step();
        end
        total++; if (vld !== 1'b0) begin bad++; $display("FAIL full_extra got=%b/%h want=0", vld, dOut); end
    endtask

    task automatic test_stall();
        logic [63:0] expD[8] = '{64'h10, 64'h20, 64'h11, 64'h21, 64'h12, 64'h22, 64'h13, 64'h23};
        logic [1:0]  expC[8] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
        logic [63:0] heldD;
        logic [1:0]  heldC;
        bit          holding;
        int          idx;
        heldD = '0;
        heldC = '0;
        holding = 1'b0;
        idx = 0;
        doReset();
        for (int c = 0; c < 20; c++) begin
            dataValid = (c < 4) ? 3'b101 : 3'b000;
            dataIn[63:0]    = 64'(8'h10 + c);
            dataIn[191:128] = 64'(8'h20 + c);
            ready = !(c >= 4 && c < 9);
            if (vld) begin
                if (holding) begin
                    total++; if (dOut !== heldD || chan !== heldC) begin bad++; $display("FAIL stall_hold c=%0d got=%h/%0d want=%h/%0d", c, dOut, chan, heldD, heldC); end
                end
                if (ready) begin
                    total++;
                    if (idx >= 8) begin
                        bad++; $display("FAIL stall_extra c=%0d got=%h want=none", c, dOut);
                    end else if (dOut !== expD[idx] || chan !== expC[idx]) begin
                        bad++; $display("FAIL stall_order n=%0d got=%h/%0d want=%h/%0d", idx, dOut, chan, expD[idx], expC[idx]);
                    end
                    idx++;
                    holding = 1'b0;
                end else begin
                    heldD = dOut;
                    heldC = chan;
                    holding = 1'b1;
                end
            end
            step();
        end
        total++; if (idx != 8)     begin bad++; $display("FAIL stall_count got=%0d want=8", idx); end
        total++; if (vld !== 1'b0) begin bad++; $display("FAIL stall_idle got=%b want=0", vld); end
    endtask

    task automatic test_reset_flush();
        doReset();
        ready = 1'b0;
        dataValid = 3'b111;
        dataIn = {64'hD2, 64'hD1, 64'hD0};
        step();
        dataValid = 3'b001;
        dataIn[63:0] = 64'hD3;
        step();
        dataValid = 3'b000;
        total++; if (vld !== 1'b1 || dOut !== 64'hD0) begin bad++; $display("FAIL flush_pre got=%b/%h want=1/d0", vld, dOut); end
        rstN = 1'b0;
        step();
        rstN = 1'b1;
        ready = 1'b1;
        total++; if (vld !== 1'b0 || dOut !== 64'h0 || chan !== 2'd0) begin bad++; $display("FAIL flush_out got=%b/%h/%0d want=0/0/0", vld, dOut, chan); end
        total++; if (grant !== 3'b111) begin bad++; $display("FAIL flush_grant got=%b want=111", grant); end
        for (int c = 0; c < 5; c++) begin
            step();
            total++; if (vld !== 1'b0) begin bad++; $display("FAIL flush_leak c=%0d got=%b/%h want=0", c, vld, dOut); end
        end
    endtask

    initial begin
        rstN      = 1'b0;
        dataValid = 3'b000;
        dataIn    = '0;
        ready     = 1'b1;
        test_reset();
        test_first_word();
        test_round_robin();
        test_full();
        test_stall();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
